// File: rtl/if_stage_pkg.sv
// if_stage_pkg: CPU-wide scalar types plus the ID->IF branch bus and IF->ID instruction bus.
package cpu_params;
  typedef logic [31:0] ProgramCount;
  typedef logic [31:0] CpuData;
endpackage

package id_stage_params;
  import cpu_params::*;
  typedef struct packed {
    logic        branch_taken;
    ProgramCount branch_target;
  } IDToIFBranchBusData;
endpackage

package if_stage_params;
  import cpu_params::*;
  localparam ProgramCount RESET_VECTOR = 32'hBFC00000;
  typedef struct packed {
    logic        valid;
    ProgramCount program_count;
    CpuData      instruction;
  } IFToIDInstructionBusData;
endpackage

// File: rtl/if_stage.sv
// if_stage: pre-IF address generation, IF instruction register with read-data buffer, delayed-branch handling.
module if_stage
  import cpu_params::*, id_stage_params::*, if_stage_params::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_allow_in,
  input  IDToIFBranchBusData      id_to_if_branch_bus,
  output IFToIDInstructionBusData if_to_id_instruction_bus,
  output logic                    instruction_sram_enabled,
  output logic [3:0]              instruction_sram_write_enabled,
  output ProgramCount             instruction_sram_address,
  output CpuData                  instruction_sram_write_data,
  input  CpuData                  instruction_sram_read_data
);
  logic        r_if_valid;
  ProgramCount r_if_pc;
  logic        r_buf_valid;
  CpuData      r_buf_data;
  logic        r_br_armed;
  logic        r_br_slot;
  ProgramCount r_br_target;
  logic        w_if_ready_go;
  logic        w_if_allow_in;
  logic        w_issue;
  logic        w_transfer;
  logic        w_take_pending;
  logic        w_take_now;
  logic        w_capture;
  logic        w_latch;
  ProgramCount w_next_pc;
  assign w_if_ready_go  = 1'b1;
  assign w_if_allow_in  = !r_if_valid || (w_if_ready_go && id_allow_in);
  assign w_issue        = w_if_allow_in && !reset;
  assign w_transfer     = r_if_valid && w_if_ready_go && id_allow_in;
  assign w_take_pending = r_br_armed && !r_br_slot;
  assign w_take_now     = id_to_if_branch_bus.branch_taken && r_if_valid;
  assign w_next_pc      = w_take_pending ? r_br_target :
                          w_take_now     ? id_to_if_branch_bus.branch_target : r_if_pc + 32'd4;
  // A branch seen while armed is the same decode instruction still waiting; never recapture it.
  assign w_capture      = id_to_if_branch_bus.branch_taken && !r_br_armed && !(w_issue && w_take_now);
  assign w_latch        = r_if_valid && !r_buf_valid && !w_transfer;
  assign instruction_sram_enabled       = w_issue;
  assign instruction_sram_address       = w_next_pc;
  assign instruction_sram_write_enabled = 4'd0;
  assign instruction_sram_write_data    = '0;
  assign if_to_id_instruction_bus = '{
    valid:         r_if_valid && w_if_ready_go,
    program_count: r_if_pc,
    instruction:   r_buf_valid ? r_buf_data : instruction_sram_read_data
  };
  always_ff @(posedge clock) begin
    if (reset) begin
      r_if_valid  <= 1'b0;
      r_if_pc     <= RESET_VECTOR - 32'd4;
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_br_armed  <= 1'b0;
      r_br_slot   <= 1'b0;
      r_br_target <= '0;
    end else begin
      if (w_issue) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= w_next_pc;
      end
      if (w_transfer) r_buf_valid <= 1'b0;
      else if (w_latch) r_buf_valid <= 1'b1;
      if (w_latch) r_buf_data <= instruction_sram_read_data;
      // The delay slot is outstanding only if it could not be fetched in the capture cycle itself.
      if (w_capture) begin
        r_br_armed  <= 1'b1;
        r_br_slot   <= !r_if_valid && !w_issue;
        r_br_target <= id_to_if_branch_bus.branch_target;
      end else if (w_issue && r_br_armed) begin
        r_br_armed <= r_br_slot;
        r_br_slot  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset. The ports SHALL be named clock and reset, and all state SHALL update on posedge clock.
REQ-002 clock  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 id_allow_in  input  1  decode stage can accept an instruction this cycle.
REQ-005 id_to_if_branch_bus  input  33  {branch_taken, branch_target[31:0]} from decode; type id_stage_params::IDToIFBranchBusData.
REQ-006 if_to_id_instruction_bus  output  65  {valid, program_count[31:0], instruction[31:0]}; type if_stage_params::IFToIDInstructionBusData.
REQ-007 instruction_sram_enabled  output  1  read strobe.
REQ-008 instruction_sram_write_enabled  output  4  byte write enables; constant 0.
REQ-009 instruction_sram_address  output  32  fetch address.
REQ-010 instruction_sram_write_data  output  32  constant 0.
REQ-011 instruction_sram_read_data  input  32  read data, valid exactly one cycle after an enabled request.

Function
REQ-012 Pre-IF SHALL compute next_pc combinationally and issue it when if_allow_in=1: instruction_sram_enabled=if_allow_in, instruction_sram_address=next_pc.
REQ-013 if_allow_in SHALL be !if_valid || (if_ready_go && id_allow_in); if_ready_go SHALL be 1.
REQ-014 On each issue, if_valid SHALL be set to 1 and if_program_count SHALL be set to next_pc at the next edge.
REQ-015 If a stage holds a valid instruction that does not advance, the stage SHALL hold its current contents, including if_valid.
REQ-016 next_pc priority: (1) pending branch target, if the pending register is armed and no delay slot is outstanding; (2) branch_target, if branch_taken and if_valid; (3) if_program_count+4, with 32-bit wrap.
REQ-017 Delay slot: when branch_taken and if_valid, the IF instruction is the delay slot. The next issued fetch after it SHALL be branch_target.
REQ-018 Branch pending register {armed, slot_outstanding, target}:
- Capture when branch_taken=1 and the target fetch is not issued in the same cycle.
- slot_outstanding SHALL be set to !if_valid at capture.
- slot_outstanding SHALL be cleared when the delay-slot fetch issues.
- armed SHALL be cleared when the target fetch issues.
REQ-019 While armed, repeated branch_taken from the same decode instruction SHALL NOT recapture.
REQ-020 Instruction buffer: in the cycle after issue, if the IF-to-decode transfer does not occur, instruction_sram_read_data SHALL be latched into buf_data and buf_valid set.
- Output instruction SHALL be buf_valid ? buf_data : instruction_sram_read_data.
- buf_valid SHALL be cleared on transfer.
REQ-021 if_to_id_instruction_bus.valid SHALL equal if_valid && if_ready_go.
REQ-022 Fetch latency SHALL be 1 cycle from address issue to the instruction being presented on the bus.
REQ-023 Throughput SHALL be one instruction per cycle with no bubbles while id_allow_in=1, including across a taken branch (delay slot is fetched, then target).
REQ-024 The block SHALL NOT generate SRAM writes.

Reset
REQ-025 While reset=1, the following SHALL hold:
- if_valid=0, buf_valid=0, armed=0, slot_outstanding=0.
- if_program_count=RESET_VECTOR-4 (0xBFBFFFFC).
- Outputs: valid=0, instruction_sram_enabled=0.
REQ-026 The first cycle after reset deasserts SHALL issue address 0xBFC00000.
REQ-027 Reset asserted mid-fetch or mid-branch SHALL discard buffered data and any pending branch, with no spurious valid afterward.

Structure
REQ-028 The package if_stage_params SHALL hold IFToIDInstructionBusData and the constant RESET_VECTOR=32'hBFC00000.
REQ-029 IDToIFBranchBusData SHALL remain in id_stage_params. ProgramCount and CpuData SHALL come from cpu_params.svh.
REQ-030 The block SHALL be a single module with no sub-module; target size is about 150-250 lines.

Verification
REQ-031 Reset release, id_allow_in=1 constant -> SRAM addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 in consecutive cycles; the bus shows each with its data one cycle later.
REQ-032 branch_taken=1 with target 0xBFC00100 while IF holds 0xBFC00004 -> next addresses issued are 0xBFC00100 then 0xBFC00104; the 0xBFC00004 delay slot is still delivered.
REQ-033 id_allow_in=0 for 3 cycles right after fetching 0xBFC00008 (data 0x24010001), SRAM data then changed -> bus holds 0xBFC00008/0x24010001 throughout; no new SRAM enable occurs.
REQ-034 branch_taken=1 while if_valid=0 -> the next fetch is pc+4 (delay slot), the following fetch is the target; armed clears after the target issues.
REQ-035 Stall with id_allow_in=0 while branch_taken=1 for 2 cycles, then id_allow_in=1 -> the target is issued exactly once; no pending-branch recapture.
REQ-036 Reset asserted the cycle after a branch is captured -> after release, fetch restarts at 0xBFC00000; the old target is never issued.
